// File: rtl/uart_mult_ctrl.sv
// uart_mult_ctrl: takes an (A, B) byte frame from the UART, issues one multiply and streams the 16-bit product back MSB first.
// Build macro UART_CTRL_CHECKSUM_EN appends a third byte, the XOR of the two product bytes, to the response.
module uart_mult_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic         clk_int,
    input  logic         uart_reset,
    input  logic [7:0]   uart_received_data,
    input  logic         uart_rx_valid,
    input  logic         uart_tx_ready,
    output logic [7:0]   uart_transmit_data,
    output logic         uart_tx_start,
    output logic [7:0]   mult_a,
    output logic [7:0]   mult_b,
    output logic         mult_start,
    input  logic         mult_done,
    input  logic [15:0]  mult_product,
    output logic         busy,
    output logic         frame_err,
    output logic         rx_drop
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned IDX_W  = 2;

`ifdef UART_CTRL_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        MULT_GO,
        MULT_WAIT,
        TX_LOAD,
        TX_BUSY,
        TX_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PROD_W-1:0]   result, result_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [BYTE_W-1:0]   a_nxt, b_nxt, data_nxt;
    logic                tx_start_nxt, frame_err_nxt;

    // Response byte selected by index
    function automatic logic [BYTE_W-1:0] tx_byte(input logic [PROD_W-1:0] r,
                                                  input logic [IDX_W-1:0]  i);
`ifdef UART_CTRL_CHECKSUM_EN
        if (i == IDX_W'(2)) return r[15:8] ^ r[7:0];
`endif
        return (i == IDX_W'(0)) ? r[15:8] : r[7:0];
    endfunction

    // Bytes arriving while a multiply or response is in flight are discarded
    assign rx_drop = uart_rx_valid && (state != IDLE) && (state != GET_B);

    // Next-state and next-register values; tx start is decided one cycle ahead so the pulse is registered
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        result_nxt    = result;
        idx_nxt       = idx;
        a_nxt         = mult_a;
        b_nxt         = mult_b;
        data_nxt      = uart_transmit_data;
        frame_err_nxt = frame_err;
        tx_start_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (uart_rx_valid) begin
                    a_nxt         = uart_received_data;
                    frame_err_nxt = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = GET_B;
                end
            end
            GET_B: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (uart_rx_valid) begin
                    b_nxt     = uart_received_data;
                    state_nxt = MULT_GO;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            MULT_GO: state_nxt = MULT_WAIT;
            MULT_WAIT: begin
                if (mult_done) begin
                    result_nxt   = mult_product;
                    idx_nxt      = '0;
                    data_nxt     = mult_product[15:8];
                    tx_start_nxt = uart_tx_ready;
                    state_nxt    = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (uart_tx_start) state_nxt = TX_BUSY;
                else               tx_start_nxt = uart_tx_ready;
            end
            TX_BUSY: begin
                if (!uart_tx_ready) state_nxt = TX_DONE;
            end
            TX_DONE: begin
                if (uart_tx_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt      = idx + IDX_W'(1);
                        data_nxt     = tx_byte(result, idx + IDX_W'(1));
                        tx_start_nxt = 1'b1;
                        state_nxt    = TX_LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            state              <= IDLE;
            cnt                <= '0;
            result             <= '0;
            idx                <= '0;
            mult_a             <= '0;
            mult_b             <= '0;
            uart_transmit_data <= '0;
            uart_tx_start      <= 1'b0;
            mult_start         <= 1'b0;
            busy               <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            result             <= result_nxt;
            idx                <= idx_nxt;
            mult_a             <= a_nxt;
            mult_b             <= b_nxt;
            uart_transmit_data <= data_nxt;
            uart_tx_start      <= tx_start_nxt;
            mult_start         <= (state_nxt == MULT_GO);
            busy               <= (state_nxt != IDLE);
            frame_err          <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_mult_ctrl.sv
// Scoreboard bench for uart_mult_ctrl: multiplier and transmitter models, expected bytes queued at stimulus time.
`timescale 1ns/1ps
module tb_uart_mult_ctrl;

    logic        clk_int = 1'b0;
    logic        uart_reset;
    logic [7:0]  uart_received_data;
    logic        uart_rx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_transmit_data;
    logic        uart_tx_start;
    logic [7:0]  mult_a, mult_b;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy, frame_err, rx_drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mult_cnt = 0;
    int mult_delay = 1;
    bit hold_ready = 1'b0;

    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] exp_tx_q[$];

    uart_mult_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_int(clk_int),
        .uart_reset(uart_reset),
        .uart_received_data(uart_received_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_transmit_data(uart_transmit_data),
        .uart_tx_start(uart_tx_start),
        .mult_a(mult_a),
        .mult_b(mult_b),
        .mult_start(mult_start),
        .mult_done(mult_done),
        .mult_product(mult_product),
        .busy(busy),
        .frame_err(frame_err),
        .rx_drop(rx_drop)
    );

    always #5 clk_int = ~clk_int;
    always @(posedge clk_int) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=event (t=%0t)", name, $time);
    endtask

    // Reference: response is the unsigned product, high byte first, optional XOR checksum
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
        exp_tx_q.push_back(p[15:8]);
        exp_tx_q.push_back(p[7:0]);
`ifdef UART_CTRL_CHECKSUM_EN
        exp_tx_q.push_back(p[15:8] ^ p[7:0]);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_int);
        uart_received_data = b;
        uart_rx_valid = 1'b1;
        @(negedge clk_int);
        uart_rx_valid = 1'b0;
        uart_received_data = 8'h00;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input int gap);
        push_frame(a, b);
        send_byte(a);
        repeat (gap) @(negedge clk_int);
        send_byte(b);
    endtask

    task automatic wait_mult();
        for (int i = 0; i < 500; i++) begin
            if (mult_start) return;
            @(negedge clk_int);
        end
        fail_now("wait_mult_start");
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 500; i++) begin
            if (uart_tx_start) return;
            @(negedge clk_int);
        end
        fail_now("wait_tx_start");
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin
                chk({name, "_resp_left"}, exp_tx_q.size(), 0);
                exp_tx_q.delete();
                return;
            end
            @(negedge clk_int);
        end
        fail_now({name, "_wait_idle"});
        exp_tx_q.delete();
    endtask

    task automatic inject_drop(input string name);
        @(negedge clk_int);
        uart_received_data = 8'hAA;
        uart_rx_valid = 1'b1;
        #1 chk({name, "_rx_drop_hi"}, rx_drop, 1);
        @(negedge clk_int);
        uart_rx_valid = 1'b0;
        #1 chk({name, "_rx_drop_lo"}, rx_drop, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_mult_a"}, mult_a, 0);
        chk({tag, "_mult_b"}, mult_b, 0);
        chk({tag, "_mult_start"}, mult_start, 0);
        chk({tag, "_tx_start"}, uart_tx_start, 0);
        chk({tag, "_tx_data"}, uart_transmit_data, 0);
        chk({tag, "_rx_drop"}, rx_drop, 0);
    endtask

    // Multiplier model: checks operands at each request, answers after mult_delay cycles
    initial begin
        logic [7:0] ea, eb;
        mult_done = 1'b0;
        mult_product = 16'h0;
        forever begin
            @(negedge clk_int);
            if (mult_start) begin
                mult_cnt++;
                if (exp_a_q.size() == 0) begin
                    fail_now("mult_start_unexpected");
                end else begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    chk("mult_a", mult_a, ea);
                    chk("mult_b", mult_b, eb);
                    repeat (mult_delay) @(negedge clk_int);
                    mult_product = 16'(ea) * 16'(eb);
                    mult_done = 1'b1;
                    @(negedge clk_int);
                    mult_done = 1'b0;
                    mult_product = 16'($urandom);
                end
            end
        end
    end

    // Transmitter model: ready drops after an accepted start for a random number of cycles
    initial begin
        int tx_cnt;
        tx_cnt = 0;
        uart_tx_ready = 1'b1;
        forever begin
            @(negedge clk_int);
            if (tx_cnt > 0) tx_cnt--;
            else if (uart_tx_start) tx_cnt = $urandom_range(2, 6);
            uart_tx_ready = (tx_cnt == 0) && !hold_ready;
        end
    end

    // Response monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_int);
            if (uart_tx_start) begin
                if (exp_tx_q.size() == 0) begin
                    fail_now("tx_start_unexpected");
                end else begin
                    e = exp_tx_q.pop_front();
                    chk("tx_byte", uart_transmit_data, e);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=hang required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, saved;
        logic [7:0] ra, rb;
        logic [15:0] p;
        uart_reset = 1'b1;
        uart_rx_valid = 1'b0;
        uart_received_data = 8'h00;
        repeat (3) @(negedge clk_int);
        check_zero("reset");
        uart_reset = 1'b0;

        // Basic frame with minimum latency
        mult_delay = 1;
        run_frame(8'h0C, 8'h0D, 2);
        wait_mult();
        t0 = cyc;
        wait_tx();
        chk("min_latency", cyc - t0, 2);
        wait_idle("frame_0c0d");

        // Maximum operands
        mult_delay = 2;
        run_frame(8'hFF, 8'hFF, 0);
        wait_idle("frame_ffff");

        // Inter-byte timeout
        saved = mult_cnt;
        send_byte(8'h05);
        repeat (14) @(negedge clk_int);
        chk("to_frame_err_early", frame_err, 0);
        chk("to_busy_early", busy, 1);
        repeat (6) @(negedge clk_int);
        chk("to_frame_err", frame_err, 1);
        chk("to_busy_idle", busy, 0);
        chk("to_no_mult_start", mult_cnt, saved);
        push_frame(8'h02, 8'h03);
        send_byte(8'h02);
        chk("to_frame_err_clear", frame_err, 0);
        send_byte(8'h03);
        wait_idle("frame_after_to");

        // Byte B in the final cycle before timeout is still accepted
        run_frame(8'h11, 8'h22, 14);
        wait_idle("frame_boundary");

        // Dropped bytes during MULT_WAIT and TX_BUSY
        mult_delay = 4;
        run_frame(8'h0C, 8'h0D, 1);
        wait_mult();
        inject_drop("drop_mult_wait");
        wait_tx();
        inject_drop("drop_tx_busy");
        wait_idle("frame_drop");

        // Transmitter not ready for 50+ cycles in TX_LOAD
        mult_delay = 3;
        hold_ready = 1'b1;
        run_frame(8'h9A, 8'h37, 3);
        wait_mult();
        n = 0;
        repeat (60) begin
            @(negedge clk_int);
            if (uart_tx_start) n++;
        end
        chk("hold_no_start", n, 0);
        p = 16'h9A * 16'h37;
        chk("hold_data_stable", uart_transmit_data, p[15:8]);
        hold_ready = 1'b0;
        wait_idle("frame_hold");

        // Reset while in TX_DONE
        mult_delay = 1;
        run_frame(8'h0C, 8'h0D, 0);
        wait_mult();
        wait_tx();
        @(negedge clk_int);
        @(negedge clk_int);
        uart_reset = 1'b1;
        exp_tx_q.delete();
        @(negedge clk_int);
        uart_reset = 1'b0;
        check_zero("mid_reset");
        repeat (40) @(negedge clk_int);
        chk("post_reset_idle", busy, 0);
        run_frame(8'h02, 8'h03, 1);
        wait_idle("frame_post_reset");

        // Random frames
        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mult_delay = $urandom_range(1, 4);
            run_frame(ra, rb, $urandom_range(0, 10));
            wait_idle("frame_rand");
            repeat ($urandom_range(0, 5)) @(negedge clk_int);
        end

        chk("ops_left", exp_a_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mult_ctrl.md
Name: uart_mult_ctrl

Overview:
Sequences the UART transceiver and the multiplier datapath. Receives a two-byte operand frame (A, B) from the UART receiver and issues one multiply. Then streams the 16-bit product back through the UART transmitter, MSB first, using its start/ready handshake. Sits between the UART wrapper and the multiplier at top level.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk_int cycles allowed between byte A and byte B before the frame is aborted.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the inter-byte timeout counter.

Ports:
clk_int  input  1  system clock; all logic on rising edge.
uart_reset  input  1  synchronous, active-high reset.
uart_received_data  input  8  byte from UART receiver.
uart_rx_valid  input  1  one-cycle pulse; uart_received_data is valid in that cycle.
uart_tx_ready  input  1  transmitter idle, so a start is accepted.
uart_transmit_data  output  8  byte to transmit.
uart_tx_start  output  1  one-cycle start pulse to the transmitter.
mult_a  output  8  operand A to the multiplier.
mult_b  output  8  operand B to the multiplier.
mult_start  output  1  one-cycle multiply request.
mult_done  input  1  one-cycle pulse; mult_product is valid in that cycle.
mult_product  input  16  multiplier result.
busy  output  1  high in every state except IDLE.
frame_err  output  1  sticky timeout flag; cleared by the next accepted byte A or by reset.
rx_drop  output  1  one-cycle pulse when an rx byte arrives outside IDLE/GET_B and is discarded.

Behaviour:
- Reset (synchronous, active-high uart_reset): state=IDLE. All outputs are 0, including mult_a, mult_b, uart_transmit_data, the result register, the byte index and the timeout counter. Reset asserted in any state aborts the current operation the same cycle; no further start pulses are issued.
- IDLE: on uart_rx_valid, latch the byte into mult_a, clear frame_err and go to GET_B with counter=0.
- GET_B: the counter increments every cycle.
  - On uart_rx_valid: latch into mult_b and go to MULT_GO.
  - If the counter reaches TIMEOUT_CYCLES-1 with no byte: set frame_err and go to IDLE.
  - uart_rx_valid in the timeout cycle wins; the byte is accepted.
- MULT_GO: mult_start=1 for exactly one cycle. mult_start is asserted the cycle after byte B is accepted. Then go to MULT_WAIT.
- MULT_WAIT: on mult_done, latch mult_product into the 16-bit result register, set idx=0 and go to TX_LOAD. There is no timeout in this state.
- TX_LOAD:
  - Drive uart_transmit_data = idx==0 ? result[15:8] : result[7:0] (plus the checksum byte when that option is compiled in).
  - When uart_tx_ready=1, pulse uart_tx_start for one cycle and go to TX_BUSY.
  - uart_transmit_data is held stable from TX_LOAD until the next byte is loaded.
- TX_BUSY: wait for uart_tx_ready=0, meaning the transmitter has accepted the byte, then go to TX_DONE.
- TX_DONE: wait for uart_tx_ready=1. Then, if idx is the last byte index, go to IDLE; otherwise idx++ and go to TX_LOAD.
- uart_rx_valid in MULT_GO, MULT_WAIT or any TX state: pulse rx_drop in the same cycle. The byte is ignored and the state is unchanged.
- mult_done outside MULT_WAIT is ignored.
- Product arithmetic is unsigned 8x8->16. The controller does not modify the product.
- busy = (state != IDLE); it is a registered state decode.
- Min frame-to-first-start latency: byte B accepted at cycle n, then mult_start at n+1. If mult_done arrives at n+2, uart_tx_start is at n+3, given uart_tx_ready=1.

Optional Feature:
Macro UART_CTRL_CHECKSUM_EN.
- Defined: the response is three bytes: result[15:8], result[7:0], then result[15:8] XOR result[7:0]. The last idx is 2.
- Undefined: the response is two bytes, the last idx is 1, and no checksum logic is synthesized.

Test Plan:
- Rx 0x0C then 0x0D; multiplier model returns 0x009C two cycles after mult_start. Required: mult_a=0x0C, mult_b=0x0D, one mult_start pulse, tx bytes 0x00 then 0x9C, busy falls after the second byte completes.
- Rx 0xFF, 0xFF; product 0xFE01. Required: tx 0xFE then 0x01; with UART_CTRL_CHECKSUM_EN, a third byte 0xFF.
- Set TIMEOUT_CYCLES=16. Rx 0x05, then nothing for 20 cycles. Required: frame_err=1 at cycle 16 after byte A, state IDLE, no mult_start. Then rx 0x02, 0x03: frame_err clears on byte 0x02 and tx returns 0x00, 0x06.
- During MULT_WAIT and TX_BUSY, inject uart_rx_valid with 0xAA. Required: a one-cycle rx_drop pulse each time and an unchanged response (0x00, 0x9C for the 0x0C x 0x0D frame).
- Hold uart_tx_ready=0 for 50 cycles in TX_LOAD. Required: no uart_tx_start until ready rises, then exactly one pulse with data stable.
- Assert uart_reset for one cycle in TX_DONE. Required: next cycle state IDLE, all outputs 0, no further uart_tx_start; a new frame is then processed correctly.
